// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer access arbiter: default geometry, the
// arbiter state encoding and the linear address calculation.
package fb_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned ADDR_W_DEF   = 19;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned COORD_W      = 11;

    // StDrain is the only state that drives a RAM write
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StScan  = 2'b01,
        StDrain = 2'b10
    } fb_state_e;

    // Row-major address y*h_active + x; callers truncate to their address width
    function automatic logic [31:0] fb_addr(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y,
                                            input int unsigned h_active);
        return 32'(y) * h_active + 32'(x);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write buffer of {addr,data} entries. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module fb_wr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 27
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Full is judged on the pre-pop pointers, so a push is refused even if a pop
    // frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares the single framebuffer RAM port between scan-out and a buffered pixel
// writer; writes drain only during blanking. FB_STATS_EN builds the OOB drop counter.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic                blank_n,
    input  logic [COORD_W-1:0]  pixel_h,
    input  logic [COORD_W-1:0]  pixel_v,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [COORD_W-1:0]  wr_x,
    input  logic [COORD_W-1:0]  wr_y,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_d,
    input  logic [DATA_W-1:0]   ram_q,
    output logic [DATA_W-1:0]   pix_index,
    output logic                pix_valid,
    output logic                oob_err,
    output logic [15:0]         oob_count
);

    localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    fb_state_e            state_q;
    logic                 rdy_q;
    logic                 oob_err_q;
    logic                 blank_d1_q;
    logic                 blank_d2_q;
    logic [ADDR_W-1:0]    ram_addr_q;
    logic [DATA_W-1:0]    ram_d_q;

    logic                 accept;
    logic                 wr_oob;
    logic                 oob_drop;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 pix_in_range;
    logic [ADDR_W-1:0]    scan_addr;

    // wr_ready stays low until the first clock after reset release
    assign wr_ready  = rdy_q && !fifo_full;
    assign accept    = wr_valid && wr_ready;
    assign wr_oob    = (wr_x >= H_LIM) || (wr_y >= V_LIM);
    assign oob_drop  = accept && wr_oob;
    assign fifo_push = accept && !wr_oob;
    assign fifo_pop  = !blank_n && !fifo_empty;

    assign fifo_wdata   = {ADDR_W'(fb_addr(wr_x, wr_y, H_ACTIVE)), wr_data};
    assign pix_in_range = (pixel_h < H_LIM) && (pixel_v < V_LIM);
    assign scan_addr    = ADDR_W'(fb_addr(pixel_h, pixel_v, H_ACTIVE));

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .vga_clk (vga_clk),
        .reset   (reset),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Port owner for the next cycle is decided purely from this cycle's inputs,
    // so rising blank_n pre-empts a drain without popping.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
        end else if (blank_n) begin
            state_q <= StScan;
            if (pix_in_range) ram_addr_q <= scan_addr;
        end else if (!fifo_empty) begin
            state_q    <= StDrain;
            ram_addr_q <= fifo_rdata[ENTRY_W-1:DATA_W];
            ram_d_q    <= fifo_rdata[DATA_W-1:0];
        end else begin
            state_q <= StIdle;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_d    = ram_d_q;
    assign ram_we   = (state_q == StDrain);

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            rdy_q      <= 1'b0;
            oob_err_q  <= 1'b0;
            blank_d1_q <= 1'b0;
            blank_d2_q <= 1'b0;
        end else begin
            rdy_q      <= 1'b1;
            oob_err_q  <= oob_drop;
            blank_d1_q <= blank_n;
            blank_d2_q <= blank_d1_q;
        end
    end

    assign oob_err   = oob_err_q;
    assign pix_valid = blank_d2_q;
    // RAM data arrives two cycles after the coordinates, aligned with blank_d2_q
    assign pix_index = blank_d2_q ? ram_q : '0;

`ifdef FB_STATS_EN
    logic [15:0] oob_count_q;

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            oob_count_q <= '0;
        end else if (oob_drop && (oob_count_q != 16'hFFFF)) begin
            oob_count_q <= oob_count_q + 16'd1;
        end
    end

    assign oob_count = oob_count_q;
`else
    assign oob_count = 16'h0;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter; the TB drives ram_q in place of the RAM.
module tb_fb_access_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b0;
    logic        blank_n = 1'b0;
    logic [10:0] pixel_h = '0;
    logic [10:0] pixel_v = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [10:0] wr_x = '0;
    logic [10:0] wr_y = '0;
    logic [7:0]  wr_data = '0;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
    logic [7:0]  pix_index;
    logic        pix_valid;
    logic        oob_err;
    logic [15:0] oob_count;

    int n_checks = 0;
    int n_fail = 0;

`ifdef FB_STATS_EN
    localparam logic [31:0] OOB_AFTER_ONE = 32'd1;
`else
    localparam logic [31:0] OOB_AFTER_ONE = 32'd0;
`endif

    fb_access_arbiter dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .blank_n   (blank_n),
        .pixel_h   (pixel_h),
        .pixel_v   (pixel_v),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q),
        .pix_index (pix_index),
        .pix_valid (pix_valid),
        .oob_err   (oob_err),
        .oob_count (oob_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic push_one(input int x, input int y, input int d);
        wr_valid = 1'b1;
        wr_x     = 11'(x);
        wr_y     = 11'(y);
        wr_data  = 8'(d);
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input int a, input int d);
        check({tag, "_we"}, 32'(ram_we), 32'd1);
        check({tag, "_addr"}, 32'(ram_addr), 32'(a));
        check({tag, "_d"}, 32'(ram_d), 32'(d));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);
        check("rst_oob_count", 32'(oob_count), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        check("post_rst_ready", 32'(wr_ready), 32'd1);

        // Scan-out read path: (5,2) -> 1285, data two cycles later
        blank_n = 1'b1;
        pixel_h = 11'd5;
        pixel_v = 11'd2;
        ram_q   = 8'h55;
        cyc();
        check("scan_addr", 32'(ram_addr), 32'd1285);
        check("scan_we", 32'(ram_we), 32'd0);
        check("scan_pv_t1", 32'(pix_valid), 32'd0);
        check("scan_pix_blanked", 32'(pix_index), 32'd0);
        ram_q = 8'hA7;
        cyc();
        check("scan_pv_t2", 32'(pix_valid), 32'd1);
        check("scan_pix_t2", 32'(pix_index), 32'hA7);

        // Fill the FIFO during active video; nothing may be written
        pixel_h = 11'd0;
        pixel_v = 11'd0;
        for (int i = 0; i < 8; i++) begin
            check("fill_ready", 32'(wr_ready), 32'd1);
            push_one(i, 1, 8'h10 + i);
            check("fill_no_we", 32'(ram_we), 32'd0);
        end
        check("full_ready", 32'(wr_ready), 32'd0);
        push_one(100, 1, 8'hEE);
        check("full_ready_hold", 32'(wr_ready), 32'd0);
        blank_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            expect_write($sformatf("drain%0d", i), 640 + i, 8'h10 + i);
        end
        check("drained_ready", 32'(wr_ready), 32'd1);
        cyc();
        check("drained_idle_we", 32'(ram_we), 32'd0);
        check("drained_idle_addr", 32'(ram_addr), 32'd647);
        check("blank_pv", 32'(pix_valid), 32'd0);
        check("blank_pix", 32'(pix_index), 32'd0);

        // Corner pixel and out-of-range write
        wr_valid = 1'b1;
        wr_x = 11'd639;
        wr_y = 11'd479;
        wr_data = 8'h3C;
        cyc();
        wr_valid = 1'b0;
        check("corner_queued_we", 32'(ram_we), 32'd0);
        cyc();
        expect_write("corner", 307199, 8'h3C);
        push_one(640, 0, 8'h5A);
        check("oob_err_pulse", 32'(oob_err), 32'd1);
        check("oob_no_we", 32'(ram_we), 32'd0);
        check("oob_count", 32'(oob_count), OOB_AFTER_ONE);
        cyc();
        check("oob_err_clear", 32'(oob_err), 32'd0);
        check("oob_no_we2", 32'(ram_we), 32'd0);

        // Drain pre-empted by blank_n with 4 entries left
        blank_n = 1'b1;
        for (int i = 0; i < 8; i++) push_one(10 + i, 3, 8'h20 + i);
        blank_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_write($sformatf("pre%0d", i), 1930 + i, 8'h20 + i);
        end
        blank_n = 1'b1;
        pixel_h = 11'd7;
        pixel_v = 11'd1;
        cyc();
        check("preempt_we", 32'(ram_we), 32'd0);
        check("preempt_addr", 32'(ram_addr), 32'd647);
        check("preempt_ready", 32'(wr_ready), 32'd1);
        cyc();
        check("preempt_we2", 32'(ram_we), 32'd0);
        blank_n = 1'b0;
        for (int i = 4; i < 8; i++) begin
            cyc();
            expect_write($sformatf("resume%0d", i), 1930 + i, 8'h20 + i);
        end
        cyc();
        check("resume_idle_we", 32'(ram_we), 32'd0);

        // Push concurrent with pop at count = DEPTH-1
        blank_n = 1'b1;
        for (int i = 0; i < 7; i++) push_one(i, 5, 8'h30 + i);
        check("seven_ready", 32'(wr_ready), 32'd1);
        blank_n  = 1'b0;
        wr_valid = 1'b1;
        wr_x     = 11'd7;
        wr_y     = 11'd5;
        wr_data  = 8'h37;
        cyc();
        wr_valid = 1'b0;
        expect_write("pp0", 3200, 8'h30);
        check("pp_ready", 32'(wr_ready), 32'd1);
        for (int i = 1; i < 8; i++) begin
            cyc();
            expect_write($sformatf("pp%0d", i), 3200 + i, 8'h30 + i);
        end
        cyc();
        check("pp_idle_we", 32'(ram_we), 32'd0);

        // Reset mid-drain with 3 entries still queued
        blank_n = 1'b1;
        for (int i = 0; i < 5; i++) push_one(i, 6, 8'h40 + i);
        blank_n = 1'b0;
        cyc();
        cyc();
        expect_write("mid1", 3841, 8'h41);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_ready", 32'(wr_ready), 32'd0);
        check("midrst_oob_count", 32'(oob_count), 32'd0);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("midrst_no_we%0d", i), 32'(ram_we), 32'd0);
        end
        check("midrst_ready_after", 32'(wr_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
